result_drain_arbiter: RTL

RESULT_DRAIN_ARBITER -- requirements
Module: result_drain_arbiter

---
 rtl/result_drain_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/result_drain_arbiter.sv
// Purpose: drains complete N-word results from per-engine FIFOs round-robin toward one write-back stream.
// Latency: one cycle from a FIFO pop to the registered output beat; sustains one beat per cycle.
// Backpressure: pops stall while a beat is held and out_ready is low; held beats stay stable.
module result_drain_arbiter #(
  parameter int BLOCK_COUNT = 29,
  parameter int K           = 128,
  parameter int N           = 32
) (
  input  logic                                      M_AXI_ACLK,
  input  logic                                      M_AXI_ARESETN,
  input  logic                                      start,
  input  logic [31:0]                               res_counts,
  output logic                                      done,
  output logic [BLOCK_COUNT-1:0]                    rd_rdy,
  input  logic [BLOCK_COUNT*K-1:0]                  rd_dout,
  input  logic [BLOCK_COUNT*($clog2(N)+1)-1:0]      rd_cnt,
  output logic [K-1:0]                              out_data,
  output logic [$clog2(BLOCK_COUNT)-1:0]            out_id,
  output logic                                      out_last,
  output logic                                      out_valid,
  input  logic                                      out_ready
);

  localparam int CW  = $clog2(N) + 1;
  localparam int IDW = $clog2(BLOCK_COUNT);

  // Sized copies of the parameters so every compare is width-matched
  localparam logic [CW-1:0]  N_CW    = CW'(N);
  localparam logic [IDW-1:0] LAST_ID = IDW'(BLOCK_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_grant;
  logic [CW-1:0]   r_pop_cnt;
  logic [31:0]     r_res_target;
  logic [31:0]     r_res_cnt;
  logic            r_done;
  logic [K-1:0]    r_out_data;
  logic [IDW-1:0]  r_out_id;
  logic            r_out_last;
  logic            r_out_valid;

  logic [K-1:0]    w_dout [BLOCK_COUNT];
  logic [CW-1:0]   w_cnt  [BLOCK_COUNT];
  logic            w_found;
  logic [IDW-1:0]  w_found_idx;
  logic            w_pop;
  logic            w_accept;
  logic            w_last_accept;
  logic [IDW-1:0]  w_next_ptr;
  logic [31:0]     w_res_cnt_inc;
  logic [BLOCK_COUNT-1:0] w_rd_rdy;

  // Unpack the flat per-FIFO buses into indexable arrays
  for (genvar gi = 0; gi < BLOCK_COUNT; gi++) begin : g_unpack
    assign w_dout[gi] = rd_dout[gi*K +: K];
    assign w_cnt[gi]  = rd_cnt[gi*CW +: CW];
  end

  // Round-robin search from r_ptr for the first FIFO holding a full result;
  // partially filled FIFOs are never eligible.
  always_comb begin
    w_found     = 1'b0;
    w_found_idx = '0;
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      int w_idx;
      w_idx = int'(r_ptr) + i;
      if (w_idx >= BLOCK_COUNT) begin
        w_idx = w_idx - BLOCK_COUNT;
      end
      if (!w_found && (w_cnt[w_idx] >= N_CW)) begin
        w_found     = 1'b1;
        w_found_idx = IDW'(w_idx);
      end
    end
  end

  // A pop happens only for the current grant, while words remain and the
  // output register is empty or being emptied this cycle; never under reset.
  assign w_pop = M_AXI_ARESETN && (r_state == S_DRAIN) && (r_pop_cnt < N_CW) &&
                 (!r_out_valid || out_ready);
  assign w_accept      = r_out_valid && out_ready;
  assign w_last_accept = w_accept && r_out_last;
  assign w_next_ptr    = (r_grant == LAST_ID) ? '0 : (r_grant + 1'b1);
  assign w_res_cnt_inc = r_res_cnt + 32'd1;

  // Pop strobe: one-hot on the granted FIFO, zero otherwise
  always_comb begin
    w_rd_rdy = '0;
    if (w_pop) begin
      w_rd_rdy[r_grant] = 1'b1;
    end
  end

  // Job FSM plus the registered output beat
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_grant      <= '0;
      r_pop_cnt    <= '0;
      r_res_target <= '0;
      r_res_cnt    <= '0;
      r_done       <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= '0;
      r_out_last   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      // Output register: load on pop, drop valid on accept without refill,
      // otherwise hold (covers the stalled case).
      if (w_pop) begin
        r_out_data  <= w_dout[r_grant];
        r_out_id    <= r_grant;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_pop_cnt == (N_CW - 1'b1));
        r_pop_cnt   <= r_pop_cnt + 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_res_target <= res_counts;
            r_res_cnt    <= '0;
            if (res_counts == 32'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SCAN;
              r_done  <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          if (w_found) begin
            r_grant   <= w_found_idx;
            r_pop_cnt <= '0;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Grant ends when its final word leaves; the search resumes past it
          if (w_last_accept) begin
            r_res_cnt <= w_res_cnt_inc;
            r_ptr     <= w_next_ptr;
            if (w_res_cnt_inc == r_res_target) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_rdy    = w_rd_rdy;
  assign done      = r_done;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

endmodule
